// File: rtl/channel_fir.sv
// Channel FIR: NTAPS-tap signed FIR with programmable taps and a 3-stage pipeline.
// Stage 1 registers the full-precision products. Stage 2 registers their sum.
// Stage 3 rounds half up, saturates, and registers the output.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid, in_sym     - input symbol strobe and signed Q9.10 symbol
//   tap_we, tap_addr,    - tap write port; writes to addresses >= NTAPS are ignored
//   tap_data
//   out_valid, out_sym   - filtered output strobe and signed Q9.10 sample
//   sat_flag             - sticky: some output has saturated since reset
module channel_fir #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned FRAC  = 10,
    parameter int unsigned NTAPS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_sym,
    input  logic                    tap_we,
    input  logic [3:0]              tap_addr,
    input  logic signed [WIDTH-1:0] tap_data,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_sym,
    output logic                    sat_flag
);

    localparam int unsigned PW = 2 * WIDTH;      // product width
    localparam int unsigned SW = 2 * WIDTH + 4;  // sum width, holds 16 products without wrap
    localparam int unsigned RW = SW + 1;         // headroom for the rounding offset

    localparam logic signed [WIDTH-1:0] TAP_ONE = WIDTH'(1) << FRAC;
    localparam logic signed [RW-1:0]    HALF    = RW'(1) << (FRAC - 1);
    localparam logic signed [RW-1:0]    MAX_V   = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0]    MIN_V   = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] x_q    [NTAPS];
    logic signed [WIDTH-1:0] x_d    [NTAPS];
    logic signed [WIDTH-1:0] h_q    [NTAPS];
    logic signed [WIDTH-1:0] h_d    [NTAPS];
    logic signed [PW-1:0]    prod_q [NTAPS];
    logic signed [PW-1:0]    prod_d [NTAPS];
    logic signed [SW-1:0]    sum_q;
    logic signed [SW-1:0]    sum_d;
    logic                    v1_q, v1_d;
    logic                    v2_q, v2_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] out_sym_q, out_sym_d;
    logic                    sat_flag_q, sat_flag_d;
    logic signed [RW-1:0]    rnd_sum;

    // Delay line shift and stage-1 products; products use pre-write taps.
    always_comb begin
        x_d = x_q;
        if (in_valid) begin
            x_d[0] = in_sym;
            for (int unsigned k = 1; k < NTAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
        for (int unsigned k = 0; k < NTAPS; k++) begin
            prod_d[k] = PW'(h_q[k]) * PW'(x_d[k]);
        end
        v1_d = in_valid;
    end

    // Tap writes; an out-of-range address matches no tap.
    always_comb begin
        h_d = h_q;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            if (tap_we && (tap_addr == 4'(k))) begin
                h_d[k] = tap_data;
            end
        end
    end

    // Stage 2: full-precision accumulation.
    always_comb begin
        sum_d = '0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            sum_d = sum_d + SW'(prod_q[k]);
        end
        v2_d = v1_q;
    end

    // Stage 3: round half up, saturate; output holds when no new sample.
    always_comb begin
        out_valid_d = v2_q;
        out_sym_d   = out_sym_q;
        sat_flag_d  = sat_flag_q;
        rnd_sum     = (RW'(sum_q) + HALF) >>> FRAC;
        if (v2_q) begin
            if (rnd_sum > MAX_V) begin
                out_sym_d  = MAX_V[WIDTH-1:0];
                sat_flag_d = 1'b1;
            end else if (rnd_sum < MIN_V) begin
                out_sym_d  = MIN_V[WIDTH-1:0];
                sat_flag_d = 1'b1;
            end else begin
                out_sym_d = rnd_sum[WIDTH-1:0];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                x_q[k]    <= '0;
                h_q[k]    <= (k == 0) ? TAP_ONE : '0;
                prod_q[k] <= '0;
            end
            sum_q       <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            sat_flag_q  <= 1'b0;
        end else begin
            x_q         <= x_d;
            h_q         <= h_d;
            prod_q      <= prod_d;
            sum_q       <= sum_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_channel_fir.sv
// Self-checking bench for channel_fir: directed cases with literal expectations,
// then randomized traffic, tap writes and reset pulses against a behavioural model.
module tb_channel_fir;

    localparam int WIDTH = 20;
    localparam int FRAC  = 10;
    localparam int NTAPS = 5;
    localparam longint OMAX = 524287;
    localparam longint OMIN = -524288;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_sym;
    logic                    tap_we;
    logic [3:0]              tap_addr;
    logic signed [WIDTH-1:0] tap_data;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_sym;
    logic                    sat_flag;

    channel_fir #(.WIDTH(WIDTH), .FRAC(FRAC), .NTAPS(NTAPS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sym   (in_sym),
        .tap_we   (tap_we),
        .tap_addr (tap_addr),
        .tap_data (tap_data),
        .out_valid(out_valid),
        .out_sym  (out_sym),
        .sat_flag (sat_flag)
    );

    typedef struct {
        int unsigned due;
        longint      val;
        bit          sat;
    } exp_t;

    exp_t        expq[$];
    longint      hm[NTAPS];
    longint      xm[NTAPS];
    longint      exp_sym;
    bit          exp_sat;
    int unsigned edge_n = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (edge %0d)", name, got, want, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NTAPS; k++) begin
            hm[k] = 0;
            xm[k] = 0;
        end
        hm[0] = 1024;
        expq.delete();
        exp_sym = 0;
        exp_sat = 0;
    endtask

    // Filter output for the current model delay line: round half up then clamp.
    task automatic model_y(output longint val, output bit sat);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) acc += hm[k] * xm[k];
        r   = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        sat = 0;
        if (r > OMAX) begin r = OMAX; sat = 1; end
        else if (r < OMIN) begin r = OMIN; sat = 1; end
        val = r;
    endtask

    // One clock cycle: drive inputs, update model, then compare every output.
    task automatic step(input bit v, input longint sym, input bit we, input int addr, input longint data);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_sym   = WIDTH'(sym);
        tap_we   = we;
        tap_addr = 4'(addr);
        tap_data = WIDTH'(data);
        if (v) begin
            for (int k = NTAPS - 1; k > 0; k--) xm[k] = xm[k-1];
            xm[0] = sym;
            model_y(e.val, e.sat);
            e.due = edge_n + 3;
            expq.push_back(e);
        end
        if (we && addr < NTAPS) hm[addr] = data;
        @(posedge clk);
        #1;
        if (expq.size() > 0 && expq[0].due == edge_n) begin
            e = expq.pop_front();
            exp_sym = e.val;
            if (e.sat) exp_sat = 1;
            chk("out_valid", 64'(out_valid), 1);
        end else begin
            chk("out_valid", 64'(out_valid), 0);
        end
        chk("out_sym", 64'(out_sym), exp_sym);
        chk("sat_flag", 64'(sat_flag), 64'(exp_sat));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic set_tap(input int addr, input longint data);
        step(0, 0, 1, addr, data);
    endtask

    task automatic flush_line();
        for (int i = 0; i < NTAPS; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) idle();
    endtask

    // Asynchronous reset pulse spanning one rising edge, with junk inputs applied.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        in_valid = 1;
        in_sym   = WIDTH'(333);
        rst_n    = 0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_sym", 64'(out_sym), 0);
        chk("rst_sat_flag", 64'(sat_flag), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        rst_n    = 1;
    endtask

    function automatic longint rand_sym();
        logic signed [WIDTH-1:0] r;
        r = WIDTH'($urandom);
        case ($urandom_range(0, 3))
            0: return 724;
            1: return -724;
            2: return longint'($urandom_range(0, 4000)) - 2000;
            default: return r;
        endcase
    endfunction

    function automatic longint rand_tap();
        logic signed [WIDTH-1:0] r;
        r = WIDTH'($urandom);
        if ($urandom_range(0, 15) == 0) return r;
        return longint'($urandom_range(0, 2048)) - 1024;
    endfunction

    initial begin
        rst_n    = 0;
        in_valid = 0;
        in_sym   = '0;
        tap_we   = 0;
        tap_addr = '0;
        tap_data = '0;
        model_reset();
        #1;
        chk("init_out_valid", 64'(out_valid), 0);
        chk("init_out_sym", 64'(out_sym), 0);
        chk("init_sat_flag", 64'(sat_flag), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        // Passthrough with reset taps, 3-cycle latency, hold afterwards.
        step(1, 724, 0, 0, 0);
        idle();
        idle();
        chk("pass_valid", 64'(out_valid), 1);
        chk("pass_sym", 64'(out_sym), 724);
        idle();
        chk("pass_hold", 64'(out_sym), 724);

        // Two half taps: 724, -724 -> 362, 0.
        for (int k = 0; k < NTAPS; k++) set_tap(k, 0);
        set_tap(0, 512);
        set_tap(1, 512);
        flush_line();
        step(1, 724, 0, 0, 0);
        step(1, -724, 0, 0, 0);
        idle();
        chk("half_a", 64'(out_sym), 362);
        idle();
        chk("half_b", 64'(out_sym), 0);
        chk("half_nosat", 64'(sat_flag), 0);

        // Saturation and sticky flag.
        set_tap(0, 1024);
        set_tap(1, 1024);
        flush_line();
        step(1, OMAX, 0, 0, 0);
        step(1, OMAX, 0, 0, 0);
        idle();
        chk("sat_first", 64'(out_sym), OMAX);
        chk("sat_first_flag", 64'(sat_flag), 0);
        idle();
        chk("sat_second", 64'(out_sym), OMAX);
        chk("sat_flag_set", 64'(sat_flag), 1);
        idle();
        idle();
        chk("sat_flag_sticky", 64'(sat_flag), 1);

        // Rounding from passthrough reset state.
        pulse_reset();
        set_tap(0, 1);
        step(1, 512, 0, 0, 0);
        idle();
        idle();
        chk("round_pos", 64'(out_sym), 1);
        step(1, -512, 0, 0, 0);
        idle();
        idle();
        chk("round_neg", 64'(out_sym), 0);
        set_tap(0, -1024);
        step(1, -724, 0, 0, 0);
        idle();
        idle();
        chk("neg_tap", 64'(out_sym), 724);

        // Tap write concurrent with a sample; out-of-range write ignored.
        set_tap(0, 1024);
        step(1, 724, 1, 0, 2048);
        step(1, 724, 0, 0, 0);
        idle();
        chk("tapwr_old", 64'(out_sym), 724);
        idle();
        chk("tapwr_new", 64'(out_sym), 1448);
        step(1, 724, 1, 15, 12345);
        idle();
        idle();
        chk("tapwr_addr15", 64'(out_sym), 1448);

        // Mid-stream reset discards in-flight samples and restores passthrough.
        step(1, 100, 0, 0, 0);
        step(1, 200, 0, 0, 0);
        pulse_reset();
        for (int i = 0; i < 4; i++) idle();
        step(1, -300, 0, 0, 0);
        idle();
        idle();
        chk("post_rst_pass", 64'(out_sym), -300);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 9) < 7, rand_sym(), $urandom_range(0, 19) == 0,
                     int'($urandom_range(0, 15)), rand_tap());
            end
        end
        for (int i = 0; i < 4; i++) idle();
        chk("queue_drained", 64'(expq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
